// File: rtl/turnstile_ctrl_if.sv
// Card-reader / passage-sensor / decoder bundle for the turnstile controller.
// master drives card reads and the passage sensor; slave is the controller.
interface turnstile_ctrl_if;
  logic       card_valid;
  logic [5:0] card_rides;
  logic       pass;
  logic [3:0] data;
  logic [3:0] data2;
  logic       gate_open;
  logic       card_wr_valid;
  logic [5:0] card_wr_rides;

  modport master (
    output card_valid, card_rides, pass,
    input  data, data2, gate_open, card_wr_valid, card_wr_rides
  );

  modport slave (
    input  card_valid, card_rides, pass,
    output data, data2, gate_open, card_wr_valid, card_wr_rides
  );
endinterface

// File: rtl/turnstile_ctrl.sv
// Turnstile controller: debits a ride per valid card, unlocks the gate until
// passage or timeout, flags forced entry, and drives two seven-segment symbol
// codes. Every output is a register computed from the next state.
module turnstile_ctrl #(
  parameter int unsigned ANIM_TICKS = 12_500_000,
  parameter int unsigned DENY_TICKS = 50_000_000,
  parameter int unsigned OPEN_TICKS = 250_000_000,
  parameter int unsigned SHOW_TICKS = 100_000_000
) (
  input  logic             clk,
  input  logic             rst,
  turnstile_ctrl_if.slave  bus
);

  localparam logic [3:0] SYM_BOT   = 4'd8;
  localparam logic [3:0] SYM_TOP   = 4'd9;
  localparam logic [3:0] SYM_N     = 4'd10;
  localparam logic [3:0] SYM_BLANK = 4'd11;
  localparam logic [3:0] SYM_G     = 4'd15;

  localparam logic [31:0] ANIM_LAST = 32'(ANIM_TICKS - 1);
  localparam logic [31:0] DENY_LAST = 32'(DENY_TICKS - 1);
  localparam logic [31:0] OPEN_LAST = 32'(OPEN_TICKS - 1);
  localparam logic [31:0] SHOW_LAST = 32'(SHOW_TICKS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DENY,
    ST_OPEN,
    ST_SHOW,
    ST_ALARM
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic        phase_q, phase_d;
  logic        pass_q;
  // Blocks a rising edge while a pass level held through reset is still high.
  logic        pass_blk_q, pass_blk_d;
  logic        wr_valid_q, wr_valid_d;
  logic [5:0]  wr_rides_q, wr_rides_d;
  logic [3:0]  data_q, data_d;
  logic [3:0]  data2_q, data2_d;
  logic        gate_q, gate_d;
  logic        pass_rise;

  // Next-state, timer, animation phase and write-back decisions.
  always_comb begin
    pass_rise  = bus.pass & ~pass_q & ~pass_blk_q;
    pass_blk_d = pass_blk_q & bus.pass;
    state_d    = state_q;
    timer_d    = timer_q + 32'd1;
    phase_d    = phase_q;
    wr_valid_d = 1'b0;
    wr_rides_d = wr_rides_q;

    case (state_q)
      ST_IDLE: begin
        if (pass_rise) begin
          // Forced entry outranks a simultaneous card read; no debit.
          state_d = ST_ALARM;
          timer_d = '0;
        end else if (bus.card_valid) begin
          timer_d = '0;
          if (bus.card_rides == 6'd0) begin
            state_d = ST_DENY;
          end else begin
            state_d    = ST_OPEN;
            wr_rides_d = bus.card_rides - 6'd1;
            wr_valid_d = 1'b1;
          end
        end else if (timer_q == ANIM_LAST) begin
          phase_d = ~phase_q;
          timer_d = '0;
        end
      end
      ST_DENY: begin
        if (pass_rise) begin
          state_d = ST_ALARM;
          timer_d = '0;
        end else if (timer_q == DENY_LAST) begin
          state_d = ST_IDLE;
          phase_d = 1'b0;
          timer_d = '0;
        end
      end
      ST_OPEN: begin
        // Passage wins over a timeout on the same cycle.
        if (pass_rise) begin
          state_d = ST_SHOW;
          timer_d = '0;
        end else if (timer_q == OPEN_LAST) begin
          state_d = ST_IDLE;
          phase_d = 1'b0;
          timer_d = '0;
        end
      end
      ST_SHOW: begin
        if (pass_rise) begin
          state_d = ST_ALARM;
          timer_d = '0;
        end else if (timer_q == SHOW_LAST) begin
          state_d = ST_IDLE;
          phase_d = 1'b0;
          timer_d = '0;
        end
      end
      ST_ALARM: begin
        // A repeated intrusion keeps the alarm up for a full period again.
        if (pass_rise) begin
          timer_d = '0;
        end else if (timer_q == DENY_LAST) begin
          state_d = ST_IDLE;
          phase_d = 1'b0;
          timer_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = 1'b0;
        timer_d = '0;
      end
    endcase
  end

  // Output decode from the next state so outputs track the state register.
  always_comb begin
    data_d  = SYM_BOT;
    data2_d = SYM_BOT;
    gate_d  = 1'b0;
    case (state_d)
      ST_IDLE: begin
        data_d  = phase_d ? SYM_TOP : SYM_BOT;
        data2_d = phase_d ? SYM_TOP : SYM_BOT;
      end
      ST_DENY: begin
        data_d  = SYM_N;
        data2_d = 4'd0;
      end
      ST_OPEN: begin
        data_d  = SYM_G;
        data2_d = SYM_BLANK;
        gate_d  = 1'b1;
      end
      ST_SHOW: begin
        data_d  = {1'b0, wr_rides_d[5:3]};
        data2_d = {1'b0, wr_rides_d[2:0]};
      end
      ST_ALARM: begin
        data_d  = SYM_N;
        data2_d = SYM_N;
      end
      default: begin
        data_d  = SYM_BOT;
        data2_d = SYM_BOT;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      phase_q    <= 1'b0;
      pass_q     <= 1'b0;
      pass_blk_q <= bus.pass;
      wr_valid_q <= 1'b0;
      wr_rides_q <= '0;
      data_q     <= SYM_BOT;
      data2_q    <= SYM_BOT;
      gate_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      phase_q    <= phase_d;
      pass_q     <= bus.pass;
      pass_blk_q <= pass_blk_d;
      wr_valid_q <= wr_valid_d;
      wr_rides_q <= wr_rides_d;
      data_q     <= data_d;
      data2_q    <= data2_d;
      gate_q     <= gate_d;
    end
  end

  assign bus.data          = data_q;
  assign bus.data2         = data2_q;
  assign bus.gate_open     = gate_q;
  assign bus.card_wr_valid = wr_valid_q;
  assign bus.card_wr_rides = wr_rides_q;

endmodule

// File: tb/tb_turnstile_ctrl.sv
// Directed bench for turnstile_ctrl with short timing parameters. Each step
// drives inputs, queues the outputs expected after the next rising edge and
// compares them 1 time unit after that edge.
module tb_turnstile_ctrl;

  localparam int unsigned ANIM = 4;
  localparam int unsigned DENY = 3;
  localparam int unsigned OPEN = 5;
  localparam int unsigned SHOW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  turnstile_ctrl_if bus ();

  turnstile_ctrl #(
    .ANIM_TICKS(ANIM),
    .DENY_TICKS(DENY),
    .OPEN_TICKS(OPEN),
    .SHOW_TICKS(SHOW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [15:0] v;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [15:0] pack(input logic [3:0] d, input logic [3:0] d2,
                                       input logic g, input logic wv,
                                       input logic [5:0] wr);
    return {d, d2, g, wv, wr};
  endfunction

  task automatic step(input string tag, input logic r, input logic cv,
                      input logic [5:0] cr, input logic ps,
                      input logic [3:0] ed, input logic [3:0] ed2,
                      input logic eg, input logic ewv, input logic [5:0] ewr);
    exp_t        e;
    exp_t        got;
    logic [15:0] obs;
    rst            = r;
    bus.card_valid = cv;
    bus.card_rides = cr;
    bus.pass       = ps;
    e.tag = tag;
    e.v   = pack(ed, ed2, eg, ewv, ewr);
    sb.push_back(e);
    @(posedge clk);
    #1;
    obs = pack(bus.data, bus.data2, bus.gate_open, bus.card_wr_valid, bus.card_wr_rides);
    got = sb.pop_front();
    checks++;
    assert (obs === got.v) else begin
      failures++;
      $error("FAIL %s: observed data=%0d data2=%0d gate=%0b wr_valid=%0b wr_rides=%0d, expected data=%0d data2=%0d gate=%0b wr_valid=%0b wr_rides=%0d",
             got.tag, obs[15:12], obs[11:8], obs[7], obs[6], obs[5:0],
             got.v[15:12], got.v[11:8], got.v[7], got.v[6], got.v[5:0]);
    end
  endtask

  initial begin
    logic [3:0] anim;
    bus.card_valid = 1'b0;
    bus.card_rides = '0;
    bus.pass       = 1'b0;

    // Reset and idle animation
    step("reset",     1, 0, 0, 0, 8, 8, 0, 0, 0);
    step("reset",     1, 0, 0, 0, 8, 8, 0, 0, 0);
    for (int k = 1; k <= 16; k++) begin
      anim = ((k / 4) % 2 == 1) ? 4'd9 : 4'd8;
      step("idle_anim", 0, 0, 0, 0, anim, anim, 0, 0, 0);
    end

    // Valid card with passage
    step("card10_open",  0, 1, 10, 0, 15, 11, 1, 1, 9);
    step("open_hold",    0, 0, 0,  0, 15, 11, 1, 0, 9);
    step("open_hold",    0, 0, 0,  0, 15, 11, 1, 0, 9);
    step("pass_show",    0, 0, 0,  1, 1,  1,  0, 0, 9);
    step("show_hold",    0, 1, 20, 1, 1,  1,  0, 0, 9);
    step("show_end",     0, 0, 0,  1, 8,  8,  0, 0, 9);
    step("idle_after",   0, 0, 0,  0, 8,  8,  0, 0, 9);

    // Empty card: deny, write-back value held
    step("empty_deny",   0, 1, 0, 0, 10, 0, 0, 0, 9);
    step("deny_hold",    0, 0, 0, 0, 10, 0, 0, 0, 9);
    step("deny_hold",    0, 0, 0, 0, 10, 0, 0, 0, 9);
    step("deny_end",     0, 0, 0, 0, 8,  8, 0, 0, 9);
    step("reset_again",  1, 0, 0, 0, 8,  8, 0, 0, 0);

    // Open timeout
    step("card1_open",   0, 1, 1, 0, 15, 11, 1, 1, 0);
    for (int k = 0; k < 4; k++)
      step("open_timer", 0, 0, 0, 0, 15, 11, 1, 0, 0);
    step("open_timeout", 0, 0, 0, 0, 8,  8,  0, 0, 0);

    // Forced entry with simultaneous card, then an extended alarm
    step("alarm_tie",    0, 1, 5, 1, 10, 10, 0, 0, 0);
    step("alarm_hold",   0, 0, 0, 1, 10, 10, 0, 0, 0);
    step("alarm_hold",   0, 0, 0, 0, 10, 10, 0, 0, 0);
    step("alarm_end",    0, 0, 0, 0, 8,  8,  0, 0, 0);
    step("idle_rise",    0, 0, 0, 1, 10, 10, 0, 0, 0);
    step("alarm_low",    0, 0, 0, 0, 10, 10, 0, 0, 0);
    step("alarm_rerise", 0, 0, 0, 1, 10, 10, 0, 0, 0);
    step("alarm_card",   0, 1, 9, 1, 10, 10, 0, 0, 0);
    step("alarm_ext",    0, 0, 0, 0, 10, 10, 0, 0, 0);
    step("alarm_ext_end",0, 0, 0, 0, 8,  8,  0, 0, 0);

    // Passage on the final open cycle beats the timeout
    step("card3_open",   0, 1, 3, 0, 15, 11, 1, 1, 2);
    for (int k = 0; k < 4; k++)
      step("open_timer", 0, 0, 0, 0, 15, 11, 1, 0, 2);
    step("tie_show",     0, 0, 0, 1, 0,  2,  0, 0, 2);
    step("tie_show2",    0, 0, 0, 1, 0,  2,  0, 0, 2);
    step("tie_show_end", 0, 0, 0, 1, 8,  8,  0, 0, 2);
    step("idle_low",     0, 0, 0, 0, 8,  8,  0, 0, 2);

    // Reset mid-operation, and a pass level held across reset
    step("card7_open",   0, 1, 7, 0, 15, 11, 1, 1, 6);
    step("open_hold",    0, 0, 0, 0, 15, 11, 1, 0, 6);
    step("rst_mid_open", 1, 0, 0, 0, 8,  8,  0, 0, 0);
    step("rst_card",     1, 1, 5, 0, 8,  8,  0, 0, 0);
    step("rst_pass_hi",  1, 0, 0, 1, 8,  8,  0, 0, 0);
    step("pass_held",    0, 0, 0, 1, 8,  8,  0, 0, 0);
    step("pass_fall",    0, 0, 0, 0, 8,  8,  0, 0, 0);
    step("pass_rerise",  0, 0, 0, 1, 10, 10, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
